// File: rtl/sample_player_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sample_player_pkg
// Description : Shared types and constants for the sample burst reader.
// Revision    : 1.0 - initial release
// ============================================================================
package sample_player_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int c_fifo_depth = 2;
    localparam int c_count_w    = 2;

endpackage
`default_nettype wire

// File: rtl/sample_fifo2.sv
`default_nettype none
// ============================================================================
// Module      : sample_fifo2
// Description : Two-entry synchronous FIFO holding samples returned by RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module sample_fifo2
    import sample_player_pkg::*;
#(
    parameter int DATA_WIDTH = 8
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic [c_count_w-1:0]  count
);

    logic [DATA_WIDTH-1:0] r_mem [c_fifo_depth];
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [c_count_w-1:0]  r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < c_fifo_depth; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign count = r_count;

    // The reader's occupancy throttle must keep these from ever firing.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (r_count == c_count_w'(c_fifo_depth))));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        !(pop && (r_count == '0)));

endmodule
`default_nettype wire

// File: rtl/sample_player.sv
`default_nettype none
// ============================================================================
// Module      : sample_player
// Description : Burst reader streaming sample RAM contents over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module sample_player
    import sample_player_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 8
)
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] base_addr,
    input  logic [ADDRESS_WIDTH-1:0] length,
    output logic                     busy,
    output logic                     done,
    output logic                     mem_rd_en,
    output logic [ADDRESS_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0]    mem_rd_data,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     out_valid,
    input  logic                     out_ready
);

    state_t                   r_state;
    state_t                   w_state_next;
    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic [ADDRESS_WIDTH-1:0] r_remaining;
    logic                     r_inflight;
    logic                     r_done;
    logic                     w_rd_en;
    logic                     w_pop;
    logic                     w_last_pop;
    logic [c_count_w-1:0]     w_count;
    logic [2:0]               w_occ;

    assign w_pop      = out_valid && out_ready;
    assign w_occ      = {1'b0, w_count} + {2'b00, r_inflight};
    // Final handshake: nothing left in flight and only one sample buffered.
    assign w_last_pop = w_pop && !r_inflight && (w_count == c_count_w'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = READ;
            READ:    if (w_rd_en && (r_remaining == '0)) w_state_next = DRAIN;
            DRAIN:   if (w_last_pop) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // A pop in this cycle frees a slot, so a read may issue at full occupancy.
    always_comb begin
        busy    = (r_state != IDLE);
        w_rd_en = (r_state == READ) && (w_occ < (3'd2 + {2'b00, w_pop}));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr      <= '0;
            r_remaining <= '0;
            r_inflight  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            if ((r_state == IDLE) && start) begin
                r_addr      <= base_addr;
                r_remaining <= length;
            end else if (w_rd_en) begin
                r_addr      <= r_addr + 1'b1;
                r_remaining <= r_remaining - 1'b1;
            end
            r_inflight <= w_rd_en;
            r_done     <= (r_state == DRAIN) && w_last_pop;
        end
    end

    sample_fifo2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (r_inflight),
        .push_data (mem_rd_data),
        .pop       (w_pop),
        .head      (out_data),
        .count     (w_count)
    );

    assign out_valid   = (w_count != '0);
    assign mem_rd_en   = w_rd_en;
    assign mem_rd_addr = r_addr;
    assign done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_sample_player.sv
`default_nettype none
// ============================================================================
// Module      : tb_sample_player
// Description : Directed self-checking bench for the sample burst reader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sample_player;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] base_addr = '0;
    logic [7:0] length = '0;
    logic       busy, done, mem_rd_en, out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] mem_rd_addr, out_data;
    logic [7:0] mem_rd_data = '0;

    int n_checks = 0;
    int n_errors = 0;

    sample_player #(.ADDRESS_WIDTH(8), .DATA_WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .base_addr   (base_addr),
        .length      (length),
        .busy        (busy),
        .done        (done),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
    );

    always #5 clk = ~clk;

    // Sample RAM with RAM[i] = i, one cycle read latency.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem_rd_addr;
    end

    // Reference occupancy model and output log, updated each falling edge.
    logic [7:0] got_q [$];
    int   done_cnt   = 0;
    int   occ_viol   = 0;
    int   valid_viol = 0;
    int   stall_viol = 0;
    int   buf_m      = 0;
    int   infl_m     = 0;
    logic pv_stall   = 1'b0;
    logic [7:0] pv_data = '0;
    logic mon_pop;

    always @(negedge clk) begin
        if (rst) begin
            buf_m    = 0;
            infl_m   = 0;
            pv_stall = 1'b0;
        end else begin
            mon_pop = out_valid && out_ready;
            if (mem_rd_en && (buf_m + infl_m - int'(mon_pop)) >= 2) occ_viol++;
            if (out_valid !== (buf_m > 0)) valid_viol++;
            if (pv_stall && (!out_valid || out_data !== pv_data)) stall_viol++;
            pv_stall = out_valid && !out_ready;
            pv_data  = out_data;
            if (mon_pop) got_q.push_back(out_data);
            if (done) done_cnt++;
            buf_m  = buf_m + infl_m - int'(mon_pop);
            infl_m = int'(mem_rd_en);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  busy,        0);
        check({tag, "_done"},  done,        0);
        check({tag, "_rd_en"}, mem_rd_en,   0);
        check({tag, "_addr"},  mem_rd_addr, 0);
        check({tag, "_valid"}, out_valid,   0);
        check({tag, "_data"},  out_data,    0);
    endtask

    // Starts a burst from the current point (start is sampled at the next
    // rising edge) and returns at the falling edge of the done cycle.
    // mode 0: out_ready always high; mode 1: out_ready pattern 1,0,0,1,0,0...
    task automatic run_burst(input string tag, input logic [7:0] base,
                             input logic [7:0] len, input int mode);
        int         q0, d0, k, n, bad;
        bit         seen;
        logic [7:0] e;
        q0 = got_q.size();
        d0 = done_cnt;
        n  = int'(len) + 1;
        start = 1'b1; base_addr = base; length = len;
        seen = 1'b0; k = 0;
        while (!seen && k < 2000) begin
            tick();
            start = 1'b0;
            k++;
            out_ready = (mode == 0) ? 1'b1 : ((k % 3) == 1);
            sample();
            if (done) seen = 1'b1;
        end
        check({tag, "_done_seen"}, seen, 1);
        if (mode == 0) check({tag, "_done_cycle"}, k, n + 3);
        check({tag, "_busy_at_done"}, busy, 0);
        check({tag, "_done_once"}, done_cnt - d0, 1);
        check({tag, "_count"}, got_q.size() - q0, n);
        bad = 0;
        for (int i = 0; i < n && (q0 + i) < got_q.size(); i++) begin
            e = base + 8'(i);
            if (got_q[q0 + i] !== e) bad++;
        end
        check({tag, "_order_errs"}, bad, 0);
        if (got_q.size() > q0) check({tag, "_first"}, got_q[q0], base);
    endtask

    initial begin
        int q0, d0;

        // Reset state
        tick(); tick();
        sample();
        check_all_zero("rst_hold");
        tick();
        rst = 1'b0;
        sample();
        check_all_zero("rst_after");

        // Base 0x10, length 3, out_ready high, cycle-exact
        tick();
        out_ready = 1'b1; start = 1'b1; base_addr = 8'h10; length = 8'd3;
        sample();
        check("t1_c0_busy", busy, 0);
        for (int c = 1; c <= 8; c++) begin
            tick();
            start = 1'b0;
            sample();
            check($sformatf("t1_c%0d_busy", c),  busy,      (c <= 6));
            check($sformatf("t1_c%0d_done", c),  done,      (c == 7));
            check($sformatf("t1_c%0d_rd_en", c), mem_rd_en, (c <= 4));
            if (c <= 4) check($sformatf("t1_c%0d_addr", c), mem_rd_addr, 8'h10 + c - 1);
            check($sformatf("t1_c%0d_valid", c), out_valid, (c >= 3 && c <= 6));
            if (c >= 3 && c <= 6) check($sformatf("t1_c%0d_data", c), out_data, 8'h10 + c - 3);
        end

        // Address wrap FE, FF, 00, 01
        run_burst("t2_wrap", 8'hFE, 8'd3, 0);

        // Backpressure pattern
        run_burst("t3_bp", 8'h50, 8'd7, 1);

        // Length 0 with start held during READ
        tick();
        out_ready = 1'b1; start = 1'b1; base_addr = 8'h40; length = 8'd0;
        q0 = got_q.size();
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c == 1) base_addr = 8'h99;
            else        start = 1'b0;
            sample();
            check($sformatf("t4_c%0d_rd_en", c), mem_rd_en, (c == 1));
            if (c == 1) check("t4_c1_addr", mem_rd_addr, 8'h40);
            if (c == 3) check("t4_c3_valid", out_valid, 1);
            if (c == 3) check("t4_c3_data", out_data, 8'h40);
            check($sformatf("t4_c%0d_done", c), done, (c == 4));
            check($sformatf("t4_c%0d_busy", c), busy, (c <= 3));
        end
        check("t4_count", got_q.size() - q0, 1);

        // Reset after three of eight outputs
        tick();
        start = 1'b1; base_addr = 8'h20; length = 8'd7;
        q0 = got_q.size();
        for (int c = 1; c <= 5; c++) begin
            tick();
            start = 1'b0;
            sample();
        end
        check("t5_three_out", got_q.size() - q0, 3);
        tick();
        rst = 1'b1;
        #1;
        check_all_zero("t5_in_rst");
        tick();
        rst = 1'b0;
        q0 = got_q.size();
        for (int c = 0; c < 4; c++) begin
            tick();
            sample();
        end
        check("t5_no_stale", got_q.size() - q0, 0);
        check_all_zero("t5_post_rst");
        run_burst("t5_clean", 8'h30, 8'd3, 0);

        // Start in the done cycle, full 256-sample burst
        run_burst("t6_pre", 8'hA0, 8'd2, 0);
        run_burst("t6_full", 8'h80, 8'd255, 0);
        d0 = done_cnt;
        for (int c = 0; c < 4; c++) begin
            tick();
            sample();
        end
        check("t6_no_extra_done", done_cnt - d0, 0);
        check("t6_idle_busy", busy, 0);

        check("occupancy_violations", occ_viol, 0);
        check("valid_model_violations", valid_viol, 0);
        check("stall_violations", stall_viol, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
